// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the async FIFO read side.
//               Holds default widths, the legal memory read latencies and the
//               derivation of the output buffer depth from the read latency.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DATASIZE_DEFAULT = 8;
  localparam int ADDRSIZE_DEFAULT = 4;

  // Legal memory read latencies (rclk cycles from raddr to data)
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  // One slot per cycle of read latency plus two for full-rate streaming
  function automatic int buf_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  // Width needed to count 0..buf_depth words
  function automatic int level_width(input int rd_lat);
    return $clog2(buf_depth(rd_lat) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : rd_out_buf
// Description : Small circular register FIFO with push/pop, occupancy count
//               and registered head word. Push is honoured only when there is
//               room (or a pop frees a slot in the same edge); pop is ignored
//               while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_out_buf #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] count,
  output logic             not_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [LVL_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  // Indices wrap modulo DEPTH, which need not be a power of two
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign w_pop_ok  = pop && (r_count != '0);
  assign w_push_ok = push && ((r_count != LVL_W'(DEPTH)) || w_pop_ok);

  // Storage, indices and occupancy; reset discards every buffered word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_idx] <= push_data;
        r_wr_idx        <= next_idx(r_wr_idx);
      end
      if (w_pop_ok) begin
        r_rd_idx <= next_idx(r_rd_idx);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head      = r_mem[r_rd_idx];
  assign count     = r_count;
  assign not_empty = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module      : rd_fwft_stage
// Description : Read-side first-word-fall-through output stage of the async
//               FIFO. Issues rinc whenever the buffer plus any word still in
//               the memory read pipeline leaves room, lands the returned data
//               in rd_out_buf and presents it as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_fwft_stage
  import fifo_pkg::*;
#(
  parameter  int DATASIZE  = DATASIZE_DEFAULT,
  parameter  int RD_LAT    = RD_LAT_COMB,
  localparam int BUF_DEPTH = buf_depth(RD_LAT),
  localparam int LVL_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [LVL_W-1:0]    buf_level
);

  logic             w_push;
  logic             w_inflight;
  logic [LVL_W-1:0] w_count;
  logic [LVL_W:0]   w_occupancy;

  // Words already committed: buffered plus the one still inside the memory
  assign w_occupancy = {1'b0, w_count} + (LVL_W + 1)'(w_inflight);

  // Issue only from registered state so dout_ready never reaches rinc
  assign rinc = rrst_n && !rempty && (w_occupancy < (LVL_W + 1)'(BUF_DEPTH));

  generate
    if (RD_LAT == RD_LAT_REG) begin : g_lat_reg
      logic r_inflight;

      // Track the word whose data returns one edge after rinc
      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          r_inflight <= 1'b0;
        end else begin
          r_inflight <= rinc;
        end
      end

      assign w_inflight = r_inflight;
      assign w_push     = r_inflight;
    end else begin : g_lat_comb
      // Combinational read: data for the popped word is present this cycle
      assign w_inflight = 1'b0;
      assign w_push     = rinc;
    end
  endgenerate

  rd_out_buf #(
    .WIDTH (DATASIZE),
    .DEPTH (BUF_DEPTH)
  ) u_out_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (w_push),
    .push_data (rdata_mem),
    .pop       (dout_ready),
    .head      (dout),
    .count     (w_count),
    .not_empty (dout_valid)
  );

  assign buf_level = w_count;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
    (w_occupancy <= (LVL_W + 1)'(BUF_DEPTH)));

  a_no_underflow: assert property (@(posedge rclk) disable iff (!rrst_n)
    (rempty |-> !rinc));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_fwft_stage
// Description : Directed bench for rd_fwft_stage with one instance per legal
//               read latency, each fed by a small model of the upstream read
//               pointer / memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_fwft_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Upstream model, latency 0 instance
  logic [7:0] mem0 [0:1023];
  int         wptr0, rptr0;
  logic       hold0, rempty0, rinc0, valid0, ready0;
  logic [7:0] rdata0, dout0;
  logic [1:0] lvl0;

  // Upstream model, latency 1 instance
  logic [7:0] mem1 [0:1023];
  int         wptr1, rptr1;
  logic       hold1, rempty1, rinc1, valid1, ready1;
  logic [7:0] rdata1, dout1;
  logic [1:0] lvl1;

  assign rempty0 = hold0 || (rptr0 == wptr0);
  assign rempty1 = hold1 || (rptr1 == wptr1);
  assign rdata0  = mem0[rptr0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr0 <= 0;
      rptr1 <= 0;
    end else begin
      if (rinc0) rptr0 <= rptr0 + 1;
      if (rinc1) rptr1 <= rptr1 + 1;
    end
  end

  always @(posedge clk) rdata1 <= mem1[rptr1];

  rd_fwft_stage #(.DATASIZE(8), .RD_LAT(0)) u_dut0 (
    .rclk(clk), .rrst_n(rst_n), .rempty(rempty0), .rinc(rinc0),
    .rdata_mem(rdata0), .dout(dout0), .dout_valid(valid0),
    .dout_ready(ready0), .buf_level(lvl0)
  );

  rd_fwft_stage #(.DATASIZE(8), .RD_LAT(1)) u_dut1 (
    .rclk(clk), .rrst_n(rst_n), .rempty(rempty1), .rinc(rinc1),
    .rdata_mem(rdata1), .dout(dout1), .dout_valid(valid1),
    .dout_ready(ready1), .buf_level(lvl1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: words popped upstream must appear at dout once each, in order
  logic       sb_en = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         rcv0 = 0, rcv1 = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (rinc0) q0.push_back(mem0[rptr0]);
      if (rinc1) q1.push_back(mem1[rptr1]);
      if (valid0 && ready0) begin
        rcv0++;
        if (q0.size() == 0) check("sb0_extra_word", 32'd1, 32'd0);
        else                check("sb0_order", {24'd0, dout0}, {24'd0, q0.pop_front()});
      end
      if (valid1 && ready1) begin
        rcv1++;
        if (q1.size() == 0) check("sb1_extra_word", 32'd1, 32'd0);
        else                check("sb1_order", {24'd0, dout1}, {24'd0, q1.pop_front()});
      end
    end
  end

  typedef struct {
    logic       rdy;
    logic       rinc;
    logic       vld;
    logic       chk_dout;
    logic [7:0] dout;
    logic [1:0] lvl;
  } vec_t;

  vec_t t2 [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_rinc;
    int got;

    // Stream of latency-0 expectations, one row per cycle after rempty falls
    t2[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    t2[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
    t2[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
    t2[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1};
    t2[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

    rst_n = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0;
    wptr0 = 0;    wptr1 = 0;
    ready0 = 1'b0; ready1 = 1'b0;
    #1;
    check("rst_valid0", valid0, 0);
    check("rst_level0", lvl0, 0);
    check("rst_rinc0",  rinc0, 0);
    check("rst_dout0",  dout0, 0);
    check("rst_valid1", valid1, 0);
    check("rst_level1", lvl1, 0);
    check("rst_dout1",  dout1, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-stream with two words buffered
    for (int i = 0; i < 5; i++) mem0[i] = 8'hA0 + 8'(i);
    wptr0 = 5;
    tick();
    tick();
    check("t1_level_before", lvl0, 2);
    check("t1_dout_before",  dout0, 8'hA0);
    #2;
    rst_n = 1'b0;
    wptr0 = 0;
    wptr1 = 0;
    #1;
    check("t1_async_valid", valid0, 0);
    check("t1_async_level", lvl0, 0);
    check("t1_async_rinc",  rinc0, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_post_valid", valid0, 0);
      check("t1_post_level", lvl0, 0);
      check("t1_post_rinc",  rinc0, 0);
    end

    // Latency 0: three words stream out back to back
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33;
    for (int i = 0; i < 5; i++) begin
      ready0 = t2[i].rdy;
      if (i == 0) wptr0 = 3;
      #1;
      check("t2_rinc",  rinc0,  t2[i].rinc);
      check("t2_valid", valid0, t2[i].vld);
      check("t2_level", lvl0,   t2[i].lvl);
      if (t2[i].chk_dout) check("t2_dout", dout0, t2[i].dout);
      tick();
    end

    // Ready with nothing buffered and upstream empty
    ready0 = 1'b1; ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_level0", lvl0, 0);
      check("t6_rinc0",  rinc0, 0);
      check("t6_level1", lvl1, 0);
      check("t6_rinc1",  rinc1, 0);
    end

    // Latency 1: eight words, two-cycle first latency, then no bubbles
    for (int i = 0; i < 8; i++) mem1[i] = 8'(i);
    wptr1 = 8;
    #1;
    check("t3_rinc_c0",  rinc1, 1);
    check("t3_valid_c0", valid1, 0);
    tick();
    check("t3_valid_c1", valid1, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t3_valid", valid1, 1);
      check("t3_dout",  dout1, k);
    end
    tick();
    check("t3_valid_end", valid1, 0);

    // Latency 1 backpressure: only three words may be committed
    for (int i = 0; i < 5; i++) mem1[8 + i] = 8'(i);
    ready1 = 1'b0;
    wptr1  = 13;
    n_rinc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rinc1) n_rinc++;
      tick();
    end
    check("t4_rinc_count", n_rinc, 3);
    check("t4_level",      lvl1, 3);
    check("t4_dout_held",  dout1, 8'h00);
    tick();
    check("t4_dout_still", dout1, 8'h00);
    check("t4_valid_held", valid1, 1);
    ready1 = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      #1;
      if (valid1) begin
        check("t4_drain_dout", dout1, got);
        got++;
      end
      tick();
    end
    check("t4_drain_count", got, 5);
    tick();
    check("t4_drain_empty", valid1, 0);

    // Toggling empty with random backpressure, checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      mem0[wptr0 + i] = 8'($urandom);
      mem1[wptr1 + i] = 8'($urandom);
    end
    q0.delete(); q1.delete();
    sb_en = 1'b1;
    wptr0 = wptr0 + 200;
    wptr1 = wptr1 + 200;
    for (int c = 0; c < 200; c++) begin
      hold0  = c[0];
      hold1  = c[0];
      ready0 = 1'($urandom_range(0, 1));
      ready1 = 1'($urandom_range(0, 1));
      tick();
    end
    hold0 = 1'b0; hold1 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1;
    for (int c = 0; c < 600 && (rptr0 != wptr0 || rptr1 != wptr1 || valid0 || valid1); c++) begin
      tick();
    end
    tick();
    sb_en = 1'b0;
    check("t5_recv0",     rcv0, 200);
    check("t5_recv1",     rcv1, 200);
    check("t5_leftover0", q0.size(), 0);
    check("t5_leftover1", q1.size(), 0);
    check("t5_valid0",    valid0, 0);
    check("t5_valid1",    valid1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rd_fwft_stage.md
Name: rd_fwft_stage

Overview:
- Read-side output stage of the async FIFO, in the rclk domain, directly downstream of the read-pointer/empty logic and the dual-port memory read port.
- Drives the read-increment strobe and captures memory read data into a small register buffer.
- Presents a first-word-fall-through valid/ready stream to the read-domain consumer.
- Isolates the consumer from memory read latency and from the registered-empty timing.

Parameters:
- DATASIZE, 8, width of a FIFO word.
- RD_LAT, 0, memory read latency in rclk cycles. 0 = combinational read of the current raddr. 1 = registered read port, data valid one cycle after raddr. Only 0 and 1 are legal.
- BUF_DEPTH, RD_LAT+2, number of output buffer entries. Derived; not to be overridden.

Ports:
- rclk  in  1  read-domain clock
- rrst_n  in  1  read-domain reset, asynchronous, active-low
- rempty  in  1  registered empty flag from the read-pointer logic
- rinc  out  1  read increment to the read-pointer logic; one word popped per cycle asserted
- rdata_mem  in  DATASIZE  memory read data for the current raddr (delayed by RD_LAT)
- dout  out  DATASIZE  head word of the output buffer
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout this cycle
- buf_level  out  $clog2(BUF_DEPTH+1)  number of valid words in the output buffer

Behaviour:
- Reset (rrst_n low, async): buffer count=0, inflight=0, dout=0, dout_valid=0, buf_level=0. rinc=0 because rempty resets to 1; rinc is additionally forced to 0 while in reset. Buffered and in-flight words are discarded.
- rinc = !rempty && (count + inflight < BUF_DEPTH).
  - Combinational from registered state only; no path from dout_ready to rinc.
- RD_LAT=0: when rinc=1, rdata_mem is written into the buffer at the same rclk edge.
- RD_LAT=1: when rinc=1, the inflight bit is set. At the next edge rdata_mem is written into the buffer and inflight clears, unless a new rinc re-sets it.
- Pop: dout_valid && dout_ready at a rising edge removes the head word. Next entry becomes head in the same edge, so dout updates one cycle after the pop.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- dout_valid = (count != 0), registered. dout = head entry, registered. dout holds stable while dout_valid && !dout_ready.
- Latency, FIFO non-empty to dout_valid: 1+RD_LAT rclk cycles after rempty deasserts with an empty buffer.
  - Example, RD_LAT=0: rempty falls at edge N, rinc=1 in cycle N, dout_valid=1 after edge N+1.
- Throughput: one word per rclk sustained when rempty=0 and dout_ready=1, for both RD_LAT values.
- Overflow protection: count + inflight never exceeds BUF_DEPTH. Assertion required.
- Underflow protection: rinc never asserted while rempty=1. Assertion required.
- Buffer storage: circular array of BUF_DEPTH entries with rd/wr indices that wrap modulo BUF_DEPTH. count is DATASIZE-independent, range 0..BUF_DEPTH.
- dout_ready while dout_valid=0: ignored, no state change.
- rempty reasserting mid-stream: rinc drops in the same cycle. An already-issued RD_LAT=1 word still lands in the buffer.
- Ordering: words reach dout in exactly the order rinc popped them.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATASIZE/ADDRSIZE;
  - legal RD_LAT values;
  - function buf_depth(rd_lat) returning rd_lat+2;
  - level width as $clog2(buf_depth+1).
- One sub-module, rd_out_buf: generic BUF_DEPTH-entry synchronous register FIFO (push/pop/count/head) with async active-low reset.
- rd_fwft_stage adds the rinc issue logic and the inflight pipeline around rd_out_buf.

Test Plan:
1. Reset mid-stream with buf_level=2: assert rrst_n low asynchronously -> same instant dout_valid=0, buf_level=0, rinc=0. After release with rempty=1, all stay 0.
2. RD_LAT=0, memory preloaded 0x11,0x22,0x33, rempty falls at edge 0, dout_ready=1 -> rinc high cycles 0-2. dout=0x11,0x22,0x33 on consecutive cycles starting after edge 1. dout_valid drops after the last word.
3. RD_LAT=1, 8 words 0x00..0x07, dout_ready=1 -> first dout_valid 2 cycles after rempty falls, then 8 consecutive valid cycles with no bubble, in order.
4. Backpressure, RD_LAT=1, dout_ready=0 with 5 words available -> rinc asserts exactly 3 times. buf_level reaches 3, dout holds 0x00 stable. Raising dout_ready drains 0x00..0x04 in order.
5. rempty toggles every other cycle while dout_ready toggles randomly for 200 cycles -> scoreboard shows no loss, duplication or reordering; both assertions never fire.
6. dout_ready=1 while dout_valid=0 and rempty=1 -> buf_level stays 0 and rinc stays 0.
